seg_scan: RTL and testbench
===========================

# seg_scan

Time-multiplexed scanner for the board's 4-digit common-anode seven-segment display. It holds a 16-bit display word and steps through its four nibbles at a programmable rate. It drives the selected nibble into the hex-to-segment decoder and drives the matching active-low anode line. New words are double-buffered and swapped in only at frame boundaries so the display never tears. Optional leading-zero blanking and an inter-digit guard band suppress ghosting.

## Interface
- DIV, 50000: clock cycles per digit slot; legal range 4..2^20.
- GUARD, 16: cycles at the start of each slot with all anodes off; legal range 0..DIV-1.

- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- load  in  1  single-cycle strobe; captures value, dp_in and lz_blank.
- value  in  16  display word; nibble 0 is the rightmost digit.
- dp_in  in  4  decimal-point enables, one bit per digit, active-high.
- lz_blank  in  1  enables leading-zero blanking for this word.
- digit  out  4  nibble for the current slot; feeds the decoder din.
- dp  out  1  decimal point for the current slot, active-high; the integrator ORs it into decoder bit 0.
- an  out  4  anode selects, active-low; an[0] is the rightmost digit.
- frame_tick  out  1  one-cycle pulse on the last cycle of each frame.
- pending  out  1  a loaded word is waiting for the next frame swap.

## Operation
- Prescaler cnt counts 0..DIV-1. On cnt==DIV-1, cnt goes to 0 and slot sel advances 0→1→2→3→0.
- Wrap cycle: the cycle where cnt==DIV-1 and sel==3. frame_tick=1 on this cycle only.
- Load, no wrap: load=1 on a non-wrap cycle writes value, dp_in and lz_blank into the pending registers and sets pending=1. A later load before the wrap overwrites the pending registers; the newest word wins.
- Swap: on the wrap cycle, if pending=1, the pending registers copy into the display registers and pending clears.
- Load on the wrap cycle: the inputs go straight into the display registers (newest wins), any older pending word is discarded, and pending=0.
- digit = disp_val[4*sel+3 : 4*sel].
- dp = disp_dp[sel].
- Leading-zero blanking: slot sel>0 is blanked when disp_lz=1 and every nibble at index ≥ sel is zero. Slot 0 is never blanked.
- an = 4'b1111 while cnt < GUARD or when the slot is blanked. Otherwise an = ~(4'b0001 << sel).
- digit, dp, an, frame_tick and pending are functions of registered state only. There is no combinational path from any input to any output.
- Reset, asynchronous and immediate:
  - cnt=0, sel=0.
  - disp_val=0, disp_dp=0, disp_lz=0.
  - pending registers cleared, pending=0.
  - Outputs: digit=0, dp=0, frame_tick=0, pending=0.
  - an=4'b1111 when GUARD≥1; an=4'b1110 when GUARD=0.
  - A reset in mid-frame or with a word pending discards the pending word.

## Timing
- Slot length is exactly DIV cycles; frame length is exactly 4*DIV cycles.
- Counting the first cycle after rst_n deasserts as cycle 0:
  - first frame_tick at cycle 4*DIV-1, then every 4*DIV cycles;
  - sel changes on the clock edge ending cycles k*DIV-1.
- In each slot, an is 1111 for GUARD cycles, then active for DIV-GUARD cycles.
- digit and dp change on the same edge as sel, i.e. inside the guard band whenever GUARD≥1.
- pending rises on the edge that samples load. It falls on the edge ending the wrap cycle.
- Load-to-display latency: 1 to 4*DIV cycles. The new word is shown from slot 0 of the next frame.
- The block ignores load while rst_n=0.

## Test plan
Benches use DIV=8 and GUARD=2 unless stated.
- Reset and scan:
  - Stimulus: release reset, no load.
  - Required: an=1111 for cycles 0–1, 1110 for cycles 2–7, 1111 for cycles 8–9, 1101 for cycles 10–15, and so on; frame_tick high only at cycles 31, 63, ...; digit=0 throughout.
- Frame-boundary swap:
  - Stimulus: load value=16'h12AB at cycle 5.
  - Required: pending=1 from cycle 6 to cycle 31 inclusive. During frame 2, digit reads B, A, 2, 1 in slots 0–3.
- Leading-zero blanking:
  - Stimulus: load 16'h0030 with lz_blank=1.
  - Required: next frame shows an active in slots 0 and 1 only; slots 2 and 3 hold an=1111 for all 8 cycles.
  - Stimulus: load 16'h0000 with lz_blank=1.
  - Required: only slot 0 is active, showing digit 0.
- Simultaneous load and wrap:
  - Stimulus: load 16'h1111 at cycle 10, then load 16'h2222 at cycle 31.
  - Required: pending=0 at cycle 32; frame 2 shows 2 on all digits; 16'h1111 is never displayed.
- Decimal point and guard:
  - Stimulus: load dp_in=4'b0100.
  - Required: dp=1 only while sel=2.
  - Stimulus: rerun with GUARD=0.
  - Required: an is never 1111 when no slot is blanked.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 at cycle 20 with a word pending.
  - Required: an, pending and digit return to their reset values immediately, without waiting for a clock edge; after release, scan restarts from slot 0 and the display shows 0.

Source files
------------

// File: rtl/seg_scan_if.sv
// rtl/seg_scan_if.sv - load port and display outputs of the seven-segment scanner
interface seg_scan_if;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        lz_blank;
    logic [3:0]  digit;
    logic        dp;
    logic [3:0]  an;
    logic        frame_tick;
    logic        pending;

    modport master (
        output load, value, dp_in, lz_blank,
        input  digit, dp, an, frame_tick, pending
    );

    modport slave (
        input  load, value, dp_in, lz_blank,
        output digit, dp, an, frame_tick, pending
    );
endinterface

// File: rtl/seg_scan.sv
// rtl/seg_scan.sv - 4-digit seven-segment scanner with frame-synchronous double buffering
module seg_scan #(
    parameter int DIV   = 50000,
    parameter int GUARD = 16
) (
    input  logic  clk,
    input  logic  rst_n,
    seg_scan_if.slave bus
);
    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;
    logic [1:0]    sel;
    logic [15:0]   disp_val;
    logic [3:0]    disp_dp;
    logic          disp_lz;
    logic [15:0]   pend_val;
    logic [3:0]    pend_dp;
    logic          pend_lz;
    logic          pending;

    logic          slot_end;
    logic          wrap;
    logic          in_guard;
    logic          blank;
    logic [15:0]   upper;

    assign slot_end = (cnt == CNT_LAST);
    assign wrap     = slot_end && (sel == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            sel      <= 2'd0;
            disp_val <= 16'd0;
            disp_dp  <= 4'd0;
            disp_lz  <= 1'b0;
            pend_val <= 16'd0;
            pend_dp  <= 4'd0;
            pend_lz  <= 1'b0;
            pending  <= 1'b0;
        end else begin
            if (slot_end) begin
                cnt <= '0;
                sel <= sel + 2'd1;
            end else begin
                cnt <= cnt + CW'(1);
            end

            // A load on the wrap cycle bypasses the pending slot: newest word wins
            if (wrap) begin
                pending <= 1'b0;
                if (bus.load) begin
                    disp_val <= bus.value;
                    disp_dp  <= bus.dp_in;
                    disp_lz  <= bus.lz_blank;
                end else if (pending) begin
                    disp_val <= pend_val;
                    disp_dp  <= pend_dp;
                    disp_lz  <= pend_lz;
                end
            end else if (bus.load) begin
                pend_val <= bus.value;
                pend_dp  <= bus.dp_in;
                pend_lz  <= bus.lz_blank;
                pending  <= 1'b1;
            end
        end
    end

    generate
        if (GUARD == 0) begin : g_no_guard
            assign in_guard = 1'b0;
        end else begin : g_guard
            assign in_guard = (cnt < CW'(GUARD));
        end
    endgenerate

    // Slot is blank when this nibble and all more-significant ones are zero
    assign upper = disp_val >> {sel, 2'b00};
    assign blank = disp_lz && (sel != 2'd0) && (upper == 16'd0);

    assign bus.digit      = disp_val[{sel, 2'b00} +: 4];
    assign bus.dp         = disp_dp[sel];
    assign bus.an         = (in_guard || blank) ? 4'b1111 : ~(4'b0001 << sel);
    assign bus.frame_tick = wrap;
    assign bus.pending    = pending;
endmodule

// File: tb/tb_seg_scan.sv
// tb/tb_seg_scan.sv - scoreboard bench for seg_scan (DIV=8, GUARD=2 and a GUARD=0 twin)
module tb_seg_scan;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    seg_scan_if bus();
    seg_scan_if bus0();

    seg_scan #(.DIV(8), .GUARD(2)) u_dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
    seg_scan #(.DIV(8), .GUARD(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

    typedef struct {
        logic [3:0] an;
        logic [3:0] an0;
        logic [3:0] digit;
        logic       dp;
        logic       tick;
        logic       pend;
    } exp_t;

    exp_t q[$];

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic en, input logic [15:0] v, input logic [3:0] d, input logic lz);
        bus.load      = en;  bus0.load     = en;
        bus.value     = v;   bus0.value    = v;
        bus.dp_in     = d;   bus0.dp_in    = d;
        bus.lz_blank  = lz;  bus0.lz_blank = lz;
    endtask

    function automatic logic [31:0] pm(input int la);
        logic [31:0] m = 32'd0;
        if (la >= 0 && la < 31)
            for (int i = la + 1; i < 32; i++) m[i] = 1'b1;
        return m;
    endfunction

    // Expected frame: act marks slots that are not blanked, pmask is pending per cycle
    task automatic push_frame(input logic [15:0] v, input logic [3:0] d, input logic [3:0] act,
                              input logic [31:0] pmask);
        for (int c = 0; c < 32; c++) begin
            exp_t e;
            int s = c / 8;
            int k = c % 8;
            logic [3:0] on = ~(4'b0001 << s);
            e.an    = (act[s] && k >= 2) ? on : 4'b1111;
            e.an0   = act[s] ? on : 4'b1111;
            e.digit = v[4*s +: 4];
            e.dp    = d[s];
            e.tick  = (c == 31);
            e.pend  = pmask[c];
            q.push_back(e);
        end
    endtask

    task automatic run_frame(input int n, input int la, input logic [15:0] lv, input logic [3:0] ld,
                             input logic llz, input int lb, input logic [15:0] bv);
        for (int c = 0; c < n; c++) begin
            exp_t e;
            if (c == la)      drive(1'b1, lv, ld, llz);
            else if (c == lb) drive(1'b1, bv, 4'd0, 1'b0);
            else              drive(1'b0, 16'd0, 4'd0, 1'b0);
            if (q.size() == 0) begin
                vectors++;
                fails++;
                $error("FAIL scoreboard_empty observed=0 expected=1");
            end else begin
                e = q.pop_front();
                chk("an",         16'(bus.an),         16'(e.an));
                chk("an_guard0",  16'(bus0.an),        16'(e.an0));
                chk("digit",      16'(bus.digit),      16'(e.digit));
                chk("dp",         16'(bus.dp),         16'(e.dp));
                chk("frame_tick", 16'(bus.frame_tick), 16'(e.tick));
                chk("pending",    16'(bus.pending),    16'(e.pend));
            end
            @(posedge clk);
            @(negedge clk);
        end
        drive(1'b0, 16'd0, 4'd0, 1'b0);
    endtask

    initial begin
        drive(1'b1, 16'hFFFF, 4'hF, 1'b1);
        repeat (3) @(negedge clk);
        chk("rst_an",      16'(bus.an),      16'h000F);
        chk("rst_an_g0",   16'(bus0.an),     16'h000E);
        chk("rst_digit",   16'(bus.digit),   16'h0000);
        chk("rst_pending", 16'(bus.pending), 16'h0000);
        chk("rst_tick",    16'(bus.frame_tick), 16'h0000);
        drive(1'b0, 16'd0, 4'd0, 1'b0);
        rst_n = 1'b1;

        push_frame(16'h0000, 4'b0000, 4'b1111, pm(5));
        run_frame(32, 5, 16'h12AB, 4'd0, 1'b0, -1, 16'd0);

        push_frame(16'h12AB, 4'b0000, 4'b1111, pm(10));
        run_frame(32, 10, 16'h1111, 4'd0, 1'b0, 31, 16'h2222);

        push_frame(16'h2222, 4'b0000, 4'b1111, pm(6));
        run_frame(32, 6, 16'h0030, 4'b0100, 1'b1, -1, 16'd0);

        push_frame(16'h0030, 4'b0100, 4'b0011, pm(4));
        run_frame(32, 4, 16'h0000, 4'd0, 1'b1, -1, 16'd0);

        push_frame(16'h0000, 4'b0000, 4'b0001, pm(7));
        run_frame(32, 7, 16'h5678, 4'd0, 1'b0, -1, 16'd0);

        push_frame(16'h5678, 4'b0000, 4'b1111, pm(5));
        run_frame(20, 5, 16'h9999, 4'd0, 1'b0, -1, 16'd0);
        q.delete();

        chk("pre_rst_pending", 16'(bus.pending), 16'h0001);
        chk("pre_rst_digit",   16'(bus.digit),   16'h0006);
        chk("pre_rst_an",      16'(bus.an),      16'h000B);
        rst_n = 1'b0;
        #1;
        chk("async_an",      16'(bus.an),      16'h000F);
        chk("async_an_g0",   16'(bus0.an),     16'h000E);
        chk("async_pending", 16'(bus.pending), 16'h0000);
        chk("async_digit",   16'(bus.digit),   16'h0000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        push_frame(16'h0000, 4'b0000, 4'b1111, 32'd0);
        run_frame(32, -1, 16'd0, 4'd0, 1'b0, -1, 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
